extend_pipe: RTL and testbench

//  Parametrised, pipelined immediate extender. Successor to the combinational decode-stage extender.

---
 rtl/extend_pipe.sv | 101 ++++++++++
 tb/tb_extend_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/extend_pipe.sv
// Pipelined immediate extender: combinational extension captured into a
// registered output stage with a one-entry skid buffer behind it.
module extend_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned ROTATE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       Instruction,
    input  logic [1:0]        ImmSrc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ExtImm,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned SEXT_W = DATA_W - 26;

    logic [31:0]       w_imm8_zx;
    logic [63:0]       w_dbl;
    logic [5:0]        w_rot_amt;
    logic [31:0]       w_rot;
    logic [DATA_W-1:0] w_ext;
    logic              w_accept;
    logic              w_xfer;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [TAG_W-1:0]  r_main_tag;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_in_ready;

    // Rotate-right of the 8-bit immediate: take a 32-bit window out of a doubled copy.
    assign w_imm8_zx = 32'(Instruction[7:0]);
    assign w_dbl     = {w_imm8_zx, w_imm8_zx};
    assign w_rot_amt = {1'b0, Instruction[11:8], 1'b0};
    assign w_rot     = w_dbl[w_rot_amt +: 32];

    // Immediate extension selected by ImmSrc.
    always_comb begin
        w_ext = '0;
        case (ImmSrc)
            2'b00:   w_ext = (ROTATE_EN != 0) ? DATA_W'(w_rot) : DATA_W'(Instruction[7:0]);
            2'b01:   w_ext = DATA_W'(Instruction[11:0]);
            2'b10:   w_ext = {{SEXT_W{Instruction[23]}}, Instruction, 2'b00};
            2'b11:   w_ext = DATA_W'({Instruction[19:16], Instruction[11:0]});
            default: w_ext = '0;
        endcase
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = r_main_valid & out_ready;

    // Main/skid storage; in_ready is registered as the inverse of the next skid state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_tag   <= '0;
            r_in_ready   <= 1'b1;
        end else if (w_xfer) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_main_data  <= w_ext;
                r_main_tag   <= in_tag;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= w_ext;
                r_main_tag   <= in_tag;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_ext;
                r_skid_tag   <= in_tag;
                r_in_ready   <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign ExtImm    = r_main_data;
    assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe: driver queues expected results on accept,
// monitor pops and compares on every output transfer.
module tb_extend_pipe;

    typedef struct packed {
        logic [23:0] instr;
        logic [1:0]  src;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] Instruction;
    logic [1:0]  ImmSrc;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ExtImm;
    logic [4:0]  out_tag;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_wait;
    exp_t sb[$];
    int   pop_cyc[$];
    vec_t vecs[13];

    extend_pipe #(.DATA_W(32), .TAG_W(5), .ROTATE_EN(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .ImmSrc(ImmSrc), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .ExtImm(ExtImm), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every transfer against the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {27'd0, out_tag, ExtImm}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_item", {27'd0, out_tag, ExtImm}, {27'd0, e.tag, e.data});
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Present one vector, wait (bounded) for in_ready, queue its expectation, release after the edge.
    task automatic send(input int idx, input logic [4:0] tag);
        int waited;
        waited      = 0;
        in_valid    = 1'b1;
        Instruction = vecs[idx].instr;
        ImmSrc      = vecs[idx].src;
        in_tag      = tag;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        last_wait = waited;
        if (!in_ready) begin
            chk("send_timeout", 64'(waited), 64'd0);
        end else begin
            sb.push_back({vecs[idx].exp, tag});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        int          b;

        vecs[0]  = '{24'h0004FF, 2'b00, 32'hFF000000};
        vecs[1]  = '{24'h0000AB, 2'b00, 32'h000000AB};
        vecs[2]  = '{24'h000ABC, 2'b01, 32'h00000ABC};
        vecs[3]  = '{24'h05F123, 2'b11, 32'h00005123};
        vecs[4]  = '{24'hFFFFFE, 2'b10, 32'hFFFFFFF8};
        vecs[5]  = '{24'h000010, 2'b10, 32'h00000040};
        vecs[6]  = '{24'h800000, 2'b10, 32'hFE000000};
        vecs[7]  = '{24'h000F01, 2'b00, 32'h00000004};
        vecs[8]  = '{24'h000134, 2'b00, 32'h0000000D};
        vecs[9]  = '{24'h123FFF, 2'b01, 32'h00000FFF};
        vecs[10] = '{24'h0F0000, 2'b11, 32'h0000F000};
        vecs[11] = '{24'h7FFFFF, 2'b10, 32'h01FFFFFC};
        vecs[12] = '{24'h000203, 2'b00, 32'h30000000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Instruction = '0; ImmSrc = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_extimm",    64'(ExtImm),    64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);

        // T1: single item, one-cycle latency, then T2/T3 vectors singly.
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(0, 5'd1);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_latency_tag",   64'(out_tag),   64'd1);
        for (int i = 1; i < 7; i++) begin
            send(i, 5'(i + 1));
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk); #1;

        // T4: backpressure with three items.
        out_ready = 1'b0;
        in_valid = 1'b1; Instruction = vecs[0].instr; ImmSrc = vecs[0].src; in_tag = 5'd1;
        @(negedge clk);
        chk("t4_ready_1", 64'(in_ready), 64'd1);
        sb.push_back({vecs[0].exp, 5'd1});
        @(posedge clk); #1;
        Instruction = vecs[4].instr; ImmSrc = vecs[4].src; in_tag = 5'd2;
        @(negedge clk);
        chk("t4_ready_2", 64'(in_ready), 64'd1);
        sb.push_back({vecs[4].exp, 5'd2});
        @(posedge clk); #1;
        Instruction = vecs[3].instr; ImmSrc = vecs[3].src; in_tag = 5'd3;
        @(negedge clk);
        chk("t4_ready_low", 64'(in_ready), 64'd0);
        hold = ExtImm;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_data",  64'(ExtImm),   64'(hold));
            chk("t4_stall_tag",   64'(out_tag),  64'd1);
            chk("t4_stall_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3, 5'd3);
        repeat (4) @(posedge clk); #1;
        chk("t4_drained", 64'(sb.size()), 64'd0);

        // T5: eight back-to-back items with out_ready held high.
        b = pop_cyc.size();
        for (int i = 0; i < 8; i++) begin
            send(i + 5, 5'(10 + i));
            chk("t5_no_stall", 64'(last_wait), 64'd0);
        end
        repeat (3) @(posedge clk); #1;
        chk("t5_count", 64'(pop_cyc.size() - b), 64'd8);
        if (pop_cyc.size() >= b + 8)
            chk("t5_consecutive", 64'(pop_cyc[b + 7] - pop_cyc[b]), 64'd7);

        // T6: reset with both registers full.
        out_ready = 1'b0;
        send(0, 5'd20);
        send(1, 5'd21);
        chk("t6_full_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        in_valid = 1'b1; Instruction = vecs[2].instr; ImmSrc = vecs[2].src; in_tag = 5'd25;
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready",  64'(in_ready),  64'd1);
        chk("t6_extimm",    64'(ExtImm),    64'd0);
        chk("t6_out_tag",   64'(out_tag),   64'd0);
        out_ready = 1'b1;
        send(5, 5'd26);
        chk("t6_after_valid", 64'(out_valid), 64'd1);
        chk("t6_after_tag",   64'(out_tag),   64'd26);
        repeat (3) @(posedge clk); #1;
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
